// File: rtl/csr_wb_buffer_pkg.sv
// Shared core types for the CSR writeback path: ROB/CSR index widths, data width,
// and the pending CSR-write entry held until the writing instruction retires.
package csr_wb_buffer_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned ROB_IDX_W = 6;
  localparam int unsigned CSR_IDX_W = 12;

  typedef logic [ROB_IDX_W-1:0] robIdx_t;
  typedef logic [CSR_IDX_W-1:0] csrIdx_t;

  typedef struct packed {
    robIdx_t          rob_idx;
    csrIdx_t          csrIdx;
    logic [XLEN-1:0]  data;
  } csrWbEntry_t;

endpackage

// File: rtl/csr_wb_buffer.sv
// Holds speculative CSR writes until their instruction retires, forwards pending
// values to younger CSR reads, and drops everything uncommitted on a pipeline flush.
module csr_wb_buffer
  import csr_wb_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_vld,
  input  robIdx_t          i_wr_rob_idx,
  input  csrIdx_t          i_wr_csrIdx,
  input  logic [XLEN-1:0]  i_wr_data,
  output logic             o_full,
  output logic             o_empty,
  input  logic             i_commit_vld,
  input  robIdx_t          i_commit_rob_idx,
  input  logic             i_squash,
  input  csrIdx_t          i_rd_csrIdx,
  output logic             o_fwd_hit,
  output logic [XLEN-1:0]  o_fwd_data,
  output logic             o_csr_wen,
  output csrIdx_t          o_csr_widx,
  output logic [XLEN-1:0]  o_csr_wdata
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             csr_wen_q, csr_wen_d;
  csrIdx_t          csr_widx_q, csr_widx_d;
  logic [XLEN-1:0]  csr_wdata_q, csr_wdata_d;

  csrWbEntry_t      entry_q [DEPTH];
  csrWbEntry_t      wr_entry;
  logic             enq;
  logic             deq;

  assign o_full      = (count_q == CNT_W'(DEPTH));
  assign o_empty     = (count_q == '0);
  assign o_csr_wen   = csr_wen_q;
  assign o_csr_widx  = csr_widx_q;
  assign o_csr_wdata = csr_wdata_q;

  // Pointer/count bookkeeping; a flush applies after the same-cycle retirement.
  always_comb begin
    deq         = i_commit_vld && (count_q != '0) &&
                  (entry_q[head_q].rob_idx == i_commit_rob_idx);
    enq         = i_wr_vld && !o_full && !i_squash;
    wr_entry    = '{rob_idx: i_wr_rob_idx, csrIdx: i_wr_csrIdx, data: i_wr_data};
    head_d      = head_q;
    tail_d      = tail_q;
    valid_d     = valid_q;
    count_d     = count_q + CNT_W'(enq) - CNT_W'(deq);
    csr_wen_d   = deq;
    csr_widx_d  = entry_q[head_q].csrIdx;
    csr_wdata_d = entry_q[head_q].data;
    if (deq) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (enq) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    if (i_squash) begin
      valid_d = '0;
      tail_d  = head_d;
      count_d = '0;
    end
  end

  // Scan oldest to youngest so the youngest match wins; the retiring head is excluded.
  always_comb begin
    logic [PTR_W-1:0] slot;
    slot       = '0;
    o_fwd_hit  = 1'b0;
    o_fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && valid_q[slot] &&
          (entry_q[slot].csrIdx == i_rd_csrIdx) && !((i == 0) && deq)) begin
        o_fwd_hit  = 1'b1;
        o_fwd_data = entry_q[slot].data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      valid_q   <= '0;
      csr_wen_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      csr_wen_q <= csr_wen_d;
    end
  end

  // Payload storage is qualified by valid/wen, so it carries no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      entry_q[tail_q] <= wr_entry;
    end
    csr_widx_q  <= csr_widx_d;
    csr_wdata_q <= csr_wdata_d;
  end

  wr_while_full_a: assert property (@(posedge clk) disable iff (!rst) !(i_wr_vld && o_full));

endmodule

// File: tb/tb_csr_wb_buffer.sv
// Directed and random stimulus for csr_wb_buffer, checked against a queue-based
// model of the pending CSR writes.
module tb_csr_wb_buffer;
  import csr_wb_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    robIdx_t         rob;
    csrIdx_t         csr;
    logic [XLEN-1:0] data;
  } model_ent_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_wr_vld;
  robIdx_t         i_wr_rob_idx;
  csrIdx_t         i_wr_csrIdx;
  logic [XLEN-1:0] i_wr_data;
  logic            o_full;
  logic            o_empty;
  logic            i_commit_vld;
  robIdx_t         i_commit_rob_idx;
  logic            i_squash;
  csrIdx_t         i_rd_csrIdx;
  logic            o_fwd_hit;
  logic [XLEN-1:0] o_fwd_data;
  logic            o_csr_wen;
  csrIdx_t         o_csr_widx;
  logic [XLEN-1:0] o_csr_wdata;

  int errors = 0;
  int checks = 0;
  model_ent_t q[$];

  csr_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_wr_vld         (i_wr_vld),
    .i_wr_rob_idx     (i_wr_rob_idx),
    .i_wr_csrIdx      (i_wr_csrIdx),
    .i_wr_data        (i_wr_data),
    .o_full           (o_full),
    .o_empty          (o_empty),
    .i_commit_vld     (i_commit_vld),
    .i_commit_rob_idx (i_commit_rob_idx),
    .i_squash         (i_squash),
    .i_rd_csrIdx      (i_rd_csrIdx),
    .o_fwd_hit        (o_fwd_hit),
    .o_fwd_data       (o_fwd_data),
    .o_csr_wen        (o_csr_wen),
    .o_csr_widx       (o_csr_widx),
    .o_csr_wdata      (o_csr_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check combinational outputs against the model,
  // advance the model, then check the registered CSR write after the edge.
  task automatic step(input logic wv, input robIdx_t wrob, input csrIdx_t wcsr,
                      input logic [XLEN-1:0] wdat, input logic cv, input robIdx_t crob,
                      input logic sq, input csrIdx_t rcsr, input logic rv);
    bit              deq, enq, hit, exp_wen;
    logic [XLEN-1:0] fd;
    model_ent_t      hd;
    rst = rv; i_wr_vld = wv; i_wr_rob_idx = wrob; i_wr_csrIdx = wcsr; i_wr_data = wdat;
    i_commit_vld = cv; i_commit_rob_idx = crob; i_squash = sq; i_rd_csrIdx = rcsr;
    #1;
    deq = cv && (q.size() != 0) && (q[0].rob == crob);
    hit = 0;
    fd  = '0;
    hd  = '{rob: '0, csr: '0, data: '0};
    for (int j = int'(q.size()) - 1; j >= (deq ? 1 : 0); j--) begin
      if (q[j].csr == rcsr) begin
        hit = 1;
        fd  = q[j].data;
        break;
      end
    end
    chk("full", 64'(o_full), 64'(q.size() == DEPTH));
    chk("empty", 64'(o_empty), 64'(q.size() == 0));
    chk("fwd_hit", 64'(o_fwd_hit), 64'(hit));
    if (hit) chk("fwd_data", o_fwd_data, fd);
    enq     = wv && (q.size() < DEPTH) && !sq;
    exp_wen = deq && rv;
    if (deq) hd = q[0];
    if (!rv) q.delete();
    else begin
      if (deq) void'(q.pop_front());
      if (enq) q.push_back('{rob: wrob, csr: wcsr, data: wdat});
      if (sq) q.delete();
    end
    @(posedge clk);
    #1;
    chk("csr_wen", 64'(o_csr_wen), 64'(exp_wen));
    if (exp_wen) begin
      chk("csr_widx", 64'(o_csr_widx), 64'(hd.csr));
      chk("csr_wdata", o_csr_wdata, hd.data);
    end
  endtask

  task automatic wr(input robIdx_t r, input csrIdx_t c, input logic [XLEN-1:0] d);
    step(1'b1, r, c, d, 1'b0, '0, 1'b0, 12'h000, 1'b1);
  endtask

  task automatic idle(input logic cv, input robIdx_t crob, input csrIdx_t rcsr);
    step(1'b0, '0, '0, '0, cv, crob, 1'b0, rcsr, 1'b1);
  endtask

  initial begin
    rst = 1'b0; i_wr_vld = 1'b0; i_wr_rob_idx = '0; i_wr_csrIdx = '0; i_wr_data = '0;
    i_commit_vld = 1'b0; i_commit_rob_idx = '0; i_squash = 1'b0; i_rd_csrIdx = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_full", 64'(o_full), 64'(0));
    chk("rst_empty", 64'(o_empty), 64'(1));
    chk("rst_wen", 64'(o_csr_wen), 64'(0));
    chk("rst_fwd_hit", 64'(o_fwd_hit), 64'(0));
    rst = 1'b1;

    // Basic enqueue then retire.
    wr(6'd5, 12'h300, 64'hAA);
    idle(1'b1, 6'd5, 12'h300);
    chk("basic_wen", 64'(o_csr_wen), 64'(1));
    chk("basic_widx", 64'(o_csr_widx), 64'h300);
    chk("basic_wdata", o_csr_wdata, 64'hAA);
    chk("basic_empty", 64'(o_empty), 64'(1));

    // Fill, hold off the fifth write, retire head.
    for (int k = 0; k < 4; k++) wr(robIdx_t'(k + 1), csrIdx_t'(12'h301 + k), 64'(100 + k));
    chk("fill_full", 64'(o_full), 64'(1));
    idle(1'b1, 6'd1, 12'h000);
    chk("drain_not_full", 64'(o_full), 64'(0));
    for (int k = 2; k <= 4; k++) idle(1'b1, robIdx_t'(k), 12'h000);

    // Youngest pending write to a CSR is forwarded.
    wr(6'd10, 12'h340, 64'd1);
    wr(6'd11, 12'h340, 64'd2);
    idle(1'b0, '0, 12'h340);
    chk("fwd_young_hit", 64'(o_fwd_hit), 64'(1));
    chk("fwd_young_data", o_fwd_data, 64'd2);
    idle(1'b0, '0, 12'h341);
    chk("fwd_other_hit", 64'(o_fwd_hit), 64'(0));

    // Squash beats a same-cycle enqueue.
    wr(6'd12, 12'h305, 64'h55);
    step(1'b1, 6'd13, 12'h306, 64'h66, 1'b0, '0, 1'b1, 12'h306, 1'b1);
    chk("squash_empty", 64'(o_empty), 64'(1));
    chk("squash_no_wen", 64'(o_csr_wen), 64'(0));
    idle(1'b0, '0, 12'h306);

    // Commit mismatch is ignored; matching commit with enqueue keeps count.
    wr(6'd7, 12'h310, 64'h77);
    idle(1'b1, 6'd9, 12'h000);
    chk("mismatch_no_wen", 64'(o_csr_wen), 64'(0));
    step(1'b1, 6'd8, 12'h311, 64'h88, 1'b1, 6'd7, 1'b0, 12'h000, 1'b1);
    chk("commit_enq_wen", 64'(o_csr_wen), 64'(1));
    chk("commit_enq_widx", 64'(o_csr_widx), 64'h310);

    // Squash with matching commit still emits the commit.
    wr(6'd20, 12'h312, 64'h99);
    step(1'b0, '0, '0, '0, 1'b1, 6'd8, 1'b1, 12'h000, 1'b1);
    chk("sq_commit_wen", 64'(o_csr_wen), 64'(1));
    chk("sq_commit_empty", 64'(o_empty), 64'(1));

    // Reset mid-operation with a matching commit.
    wr(6'd21, 12'h313, 64'h1);
    wr(6'd22, 12'h314, 64'h2);
    step(1'b0, '0, '0, '0, 1'b1, 6'd21, 1'b0, 12'h000, 1'b0);
    chk("midrst_wen", 64'(o_csr_wen), 64'(0));
    chk("midrst_empty", 64'(o_empty), 64'(1));

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic            wv, cv, sq, rv;
      robIdx_t         wrob, crob;
      csrIdx_t         wcsr, rcsr;
      logic [XLEN-1:0] wdat;
      wv   = (q.size() < DEPTH) && ($urandom_range(0, 1) != 0);
      wrob = robIdx_t'($urandom_range(0, 63));
      wcsr = csrIdx_t'(12'h300 + $urandom_range(0, 3));
      wdat = {$urandom, $urandom};
      cv   = ($urandom_range(0, 3) != 0);
      crob = ((q.size() != 0) && ($urandom_range(0, 2) != 0)) ? q[0].rob
                                                              : robIdx_t'($urandom_range(0, 63));
      sq   = ($urandom_range(0, 19) == 0);
      rcsr = csrIdx_t'(12'h300 + $urandom_range(0, 3));
      rv   = ($urandom_range(0, 49) != 0);
      step(wv, wrob, wcsr, wdat, cv, crob, sq, rcsr, rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
